mips_multicycle_control: RTL and testbench

Multicycle main control FSM for the MIPS processor: issues the ALUOp[2:0] codes that the ALU control decoder consumes, along with every datapath strobe, for one instruction at a time. It sits between the instruction register and the datapath. It sequences fetch, decode, execute, memory and writeback using a ready handshake on the shared instruction/data memory. It also keeps a retired-instruction counter.

---
 rtl/mips_multicycle_control.sv | 201 ++++++++++++++++++++
 tb/tb_mips_multicycle_control.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips_multicycle_control.sv
// Multicycle MIPS main control: sequences fetch/decode/execute/memory/writeback
// one instruction at a time and counts retired instructions.
module mips_multicycle_control (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [5:0]  opcode,
   input  logic        zero,
   input  logic        mem_ready,
   output logic [2:0]  alu_op,
   output logic        pc_write,
   output logic        ir_write,
   output logic        mem_read,
   output logic        mem_write,
   output logic        i_or_d,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [1:0]  pc_source,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        illegal,
   output logic [15:0] instr_count,
   output logic [3:0]  state
);

   typedef enum logic [3:0] {
      S_RESET     = 4'd0,
      S_FETCH     = 4'd1,
      S_DECODE    = 4'd2,
      S_MEM_ADDR  = 4'd3,
      S_MEM_READ  = 4'd4,
      S_MEM_WB    = 4'd5,
      S_MEM_WRITE = 4'd6,
      S_R_EXEC    = 4'd7,
      S_R_WB      = 4'd8,
      S_BRANCH    = 4'd9,
      S_JUMP      = 4'd10,
      S_I_EXEC    = 4'd11,
      S_I_WB      = 4'd12
   } state_e;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_J     = 6'b000010;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ANDI  = 6'b001100;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;

   state_e      state_q, state_d;
   logic [5:0]  op_q;
   logic [15:0] instr_cnt_q;
   logic        retire_s;

   // Next-state selection; DECODE dispatches on the live opcode.
   always_comb begin
      state_d = S_FETCH;
      case (state_q)
         S_RESET:     state_d = S_FETCH;
         S_FETCH:     state_d = mem_ready ? S_DECODE : S_FETCH;
         S_DECODE: begin
            case (opcode)
               OP_RTYPE:                         state_d = S_R_EXEC;
               OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
               OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
               OP_J:                             state_d = S_JUMP;
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_I_EXEC;
               default:                          state_d = S_FETCH;
            endcase
         end
         S_MEM_ADDR:  state_d = (op_q == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
         S_MEM_READ:  state_d = mem_ready ? S_MEM_WB : S_MEM_READ;
         S_MEM_WB:    state_d = S_FETCH;
         S_MEM_WRITE: state_d = mem_ready ? S_FETCH : S_MEM_WRITE;
         S_R_EXEC:    state_d = S_R_WB;
         S_R_WB:      state_d = S_FETCH;
         S_BRANCH:    state_d = S_FETCH;
         S_JUMP:      state_d = S_FETCH;
         S_I_EXEC:    state_d = S_I_WB;
         S_I_WB:      state_d = S_FETCH;
         default:     state_d = S_FETCH;
      endcase
   end

   // An instruction retires on the edge that returns it to FETCH.
   always_comb begin
      retire_s = 1'b0;
      case (state_q)
         S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_I_WB: retire_s = 1'b1;
         S_MEM_WRITE:                                retire_s = mem_ready;
         default:                                    retire_s = 1'b0;
      endcase
   end

   // State, latched opcode and retired-instruction counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_RESET;
         op_q        <= 6'd0;
         instr_cnt_q <= 16'd0;
      end else begin
         state_q <= state_d;
         if (state_q == S_DECODE) begin
            op_q <= opcode;
         end
         if (retire_s) begin
            instr_cnt_q <= instr_cnt_q + 16'd1;
         end
      end
   end

   // Moore output decode; pc_write/ir_write additionally gate on mem_ready/zero.
   always_comb begin
      alu_op     = 3'b011;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      i_or_d     = 1'b0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      pc_source  = 2'b00;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
         end
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_J,
               OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: illegal = 1'b0;
               default:                           illegal = 1'b1;
            endcase
         end
         S_MEM_ADDR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
         end
         S_MEM_READ: begin
            mem_read = 1'b1;
            i_or_d   = 1'b1;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
         end
         S_MEM_WRITE: begin
            mem_write = 1'b1;
            i_or_d    = 1'b1;
         end
         S_R_EXEC: begin
            alu_src_a = 1'b1;
            alu_op    = 3'b111;
         end
         S_R_WB: begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
         end
         S_BRANCH: begin
            alu_src_a = 1'b1;
            alu_op    = 3'b100;
            pc_source = 2'b01;
            pc_write  = (op_q == OP_BEQ) ? zero : ~zero;
         end
         S_JUMP: begin
            pc_source = 2'b10;
            pc_write  = 1'b1;
         end
         S_I_EXEC: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            case (op_q)
               OP_ANDI: alu_op = 3'b000;
               OP_ORI:  alu_op = 3'b001;
               OP_SLTI: alu_op = 3'b101;
               default: alu_op = 3'b011;
            endcase
         end
         S_I_WB: begin
            reg_write = 1'b1;
         end
         default: begin
            alu_op = 3'b011;
         end
      endcase
   end

   assign instr_count = instr_cnt_q;
   assign state       = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Self-checking bench for mips_multicycle_control: vector table, directed
// corner sequences and randomized instructions against a sequence-level model.
module tb_mips_multicycle_control;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [5:0]  opcode = 6'd0;
   logic        zero = 1'b0;
   logic        mem_ready = 1'b0;
   logic [2:0]  alu_op;
   logic        pc_write, ir_write, mem_read, mem_write, i_or_d, alu_src_a;
   logic [1:0]  alu_src_b, pc_source;
   logic        reg_write, reg_dst, mem_to_reg, illegal;
   logic [15:0] instr_count;
   logic [3:0]  state;

   mips_multicycle_control dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .alu_op(alu_op), .pc_write(pc_write), .ir_write(ir_write), .mem_read(mem_read),
      .mem_write(mem_write), .i_or_d(i_or_d), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .pc_source(pc_source), .reg_write(reg_write), .reg_dst(reg_dst),
      .mem_to_reg(mem_to_reg), .illegal(illegal), .instr_count(instr_count), .state(state)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] alu_op;
      logic       pc_write, ir_write, mem_read, mem_write, i_or_d, alu_src_a;
      logic [1:0] alu_src_b, pc_source;
      logic       reg_write, reg_dst, mem_to_reg, illegal;
   } outs_t;

   typedef struct {
      logic [5:0] op;
      logic       z;
      int         len;
      int         last_st;
      logic       last_pw;
      logic       ill;
      logic       retire;
   } vec_t;

   int   n_checks = 0;
   int   n_fail = 0;
   int   exp_cnt = 0;
   int   exp_q[$];
   logic rdy_q[$];
   vec_t tbl [11];
   logic [5:0] legal_ops [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                  6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001010};

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   function automatic bit legal(input logic [5:0] op);
      foreach (legal_ops[k]) if (legal_ops[k] == op) return 1'b1;
      return 1'b0;
   endfunction

   function automatic outs_t act_outs();
      outs_t o;
      o.alu_op = alu_op;       o.pc_write = pc_write;   o.ir_write = ir_write;
      o.mem_read = mem_read;   o.mem_write = mem_write; o.i_or_d = i_or_d;
      o.alu_src_a = alu_src_a; o.alu_src_b = alu_src_b; o.pc_source = pc_source;
      o.reg_write = reg_write; o.reg_dst = reg_dst;     o.mem_to_reg = mem_to_reg;
      o.illegal = illegal;
      return o;
   endfunction

   // Expected strobes for one cycle, straight from the per-state output rules.
   function automatic outs_t exp_outs(input int st, input logic [5:0] op, input logic z,
                                      input logic rdy);
      outs_t o;
      o = '0;
      o.alu_op = 3'b011;
      case (st)
         1:  begin o.mem_read = 1'b1; o.alu_src_b = 2'b01; o.ir_write = rdy; o.pc_write = rdy; end
         2:  begin o.alu_src_b = 2'b11; o.illegal = !legal(op); end
         3:  begin o.alu_src_a = 1'b1; o.alu_src_b = 2'b10; end
         4:  begin o.mem_read = 1'b1; o.i_or_d = 1'b1; end
         5:  begin o.reg_write = 1'b1; o.mem_to_reg = 1'b1; end
         6:  begin o.mem_write = 1'b1; o.i_or_d = 1'b1; end
         7:  begin o.alu_src_a = 1'b1; o.alu_op = 3'b111; end
         8:  begin o.reg_write = 1'b1; o.reg_dst = 1'b1; end
         9:  begin
                o.alu_src_a = 1'b1; o.alu_op = 3'b100; o.pc_source = 2'b01;
                o.pc_write = (op == 6'b000100) ? z : !z;
             end
         10: begin o.pc_source = 2'b10; o.pc_write = 1'b1; end
         11: begin
                o.alu_src_a = 1'b1; o.alu_src_b = 2'b10;
                if (op == 6'b001100) o.alu_op = 3'b000;
                else if (op == 6'b001101) o.alu_op = 3'b001;
                else if (op == 6'b001010) o.alu_op = 3'b101;
                else o.alu_op = 3'b011;
             end
         12: begin o.reg_write = 1'b1; end
         default: o.alu_op = 3'b011;
      endcase
      return o;
   endfunction

   function automatic void push_wait(input int st, input int waits);
      for (int k = 0; k < waits; k++) begin exp_q.push_back(st); rdy_q.push_back(1'b0); end
      exp_q.push_back(st);
      rdy_q.push_back(1'b1);
   endfunction

   function automatic void push_any(input int st);
      exp_q.push_back(st);
      rdy_q.push_back(1'($urandom));
   endfunction

   // Expected state trace of one instruction, plus the mem_ready plan driving it.
   function automatic void build_seq(input logic [5:0] op, input int fw, input int mw);
      exp_q.delete();
      rdy_q.delete();
      push_wait(1, fw);
      push_any(2);
      if (op == 6'b000000) begin push_any(7); push_any(8); end
      else if (op == 6'b100011) begin push_any(3); push_wait(4, mw); push_any(5); end
      else if (op == 6'b101011) begin push_any(3); push_wait(6, mw); end
      else if (op == 6'b000100 || op == 6'b000101) push_any(9);
      else if (op == 6'b000010) push_any(10);
      else if (legal(op)) begin push_any(11); push_any(12); end
   endfunction

   task automatic run_instr(input logic [5:0] op, input logic z, input int fw, input int mw);
      build_seq(op, fw, mw);
      foreach (exp_q[i]) begin
         opcode    = (exp_q[i] == 2) ? op : 6'($urandom);
         zero      = (exp_q[i] == 9) ? z : 1'($urandom);
         mem_ready = rdy_q[i];
         #1;
         check($sformatf("state op=%b cyc%0d", op, i), 32'(state), 32'(exp_q[i]));
         check($sformatf("outs op=%b st=%0d", op, exp_q[i]), 32'(act_outs()),
               32'(exp_outs(exp_q[i], op, zero, mem_ready)));
         tick();
      end
      if (legal(op)) exp_cnt = (exp_cnt + 1) % 65536;
      #1;
      check("instr_count", 32'(instr_count), 32'(exp_cnt));
      check("back_in_fetch", 32'(state), 32'd1);
   endtask

   initial begin
      int len, last_st;
      logic last_pw, ill_dec;
      logic [5:0] rop;

      tbl[0]  = '{6'b000000, 1'b0, 4, 8,  1'b0, 1'b0, 1'b1};
      tbl[1]  = '{6'b100011, 1'b0, 5, 5,  1'b0, 1'b0, 1'b1};
      tbl[2]  = '{6'b101011, 1'b0, 4, 6,  1'b0, 1'b0, 1'b1};
      tbl[3]  = '{6'b000100, 1'b1, 3, 9,  1'b1, 1'b0, 1'b1};
      tbl[4]  = '{6'b000101, 1'b1, 3, 9,  1'b0, 1'b0, 1'b1};
      tbl[5]  = '{6'b000100, 1'b0, 3, 9,  1'b0, 1'b0, 1'b1};
      tbl[6]  = '{6'b000010, 1'b0, 3, 10, 1'b1, 1'b0, 1'b1};
      tbl[7]  = '{6'b001000, 1'b0, 4, 12, 1'b0, 1'b0, 1'b1};
      tbl[8]  = '{6'b001101, 1'b0, 4, 12, 1'b0, 1'b0, 1'b1};
      tbl[9]  = '{6'b111111, 1'b0, 2, 2,  1'b0, 1'b1, 1'b0};
      tbl[10] = '{6'b000101, 1'b0, 3, 9,  1'b1, 1'b0, 1'b1};

      // Reset state, during and just after release.
      mem_ready = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("rst state", 32'(state), 32'd0);
      check("rst outs", 32'(act_outs()), 32'(exp_outs(0, 6'd0, 1'b0, 1'b1)));
      check("rst count", 32'(instr_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("post-rst state", 32'(state), 32'd0);
      check("post-rst outs", 32'(act_outs()), 32'(exp_outs(0, 6'd0, 1'b0, 1'b1)));
      tick();

      // R-type straight after reset.
      run_instr(6'b000000, 1'b0, 0, 0);

      // Vector table with mem_ready tied high.
      foreach (tbl[r]) begin
         opcode = tbl[r].op;
         zero = tbl[r].z;
         mem_ready = 1'b1;
         len = 0;
         last_st = -1;
         last_pw = 1'b0;
         ill_dec = 1'b0;
         do begin
            #1;
            last_st = int'(state);
            last_pw = pc_write;
            if (len == 1) ill_dec = illegal;
            tick();
            len++;
         end while (state != 4'd1 && len < 12);
         if (tbl[r].retire) exp_cnt = (exp_cnt + 1) % 65536;
         check($sformatf("tbl%0d len", r), 32'(len), 32'(tbl[r].len));
         check($sformatf("tbl%0d last_state", r), 32'(last_st), 32'(tbl[r].last_st));
         check($sformatf("tbl%0d last_pc_write", r), 32'(last_pw), 32'(tbl[r].last_pw));
         check($sformatf("tbl%0d illegal", r), 32'(ill_dec), 32'(tbl[r].ill));
         check($sformatf("tbl%0d count", r), 32'(instr_count), 32'(exp_cnt));
      end

      // Directed corners: memory waits, branches, I-type ALU ops, illegal opcode.
      run_instr(6'b100011, 1'b0, 1, 2);
      run_instr(6'b101011, 1'b0, 0, 3);
      run_instr(6'b000100, 1'b1, 0, 0);
      run_instr(6'b000101, 1'b1, 0, 0);
      run_instr(6'b001000, 1'b0, 0, 0);
      run_instr(6'b001100, 1'b0, 0, 0);
      run_instr(6'b001101, 1'b0, 0, 0);
      run_instr(6'b001010, 1'b0, 0, 0);
      run_instr(6'b111111, 1'b0, 0, 0);

      // Randomized instruction stream.
      for (int n = 0; n < 60; n++) begin
         if ($urandom_range(0, 4) == 0) rop = 6'($urandom);
         else rop = legal_ops[$urandom_range(0, 9)];
         run_instr(rop, 1'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
      end

      // Counter wrap: preload 0xFFFF while idle in FETCH, then retire one j.
      mem_ready = 1'b0;
      force dut.instr_cnt_q = 16'hFFFF;
      #1;
      release dut.instr_cnt_q;
      exp_cnt = 16'hFFFF;
      #1;
      check("preload count", 32'(instr_count), 32'(exp_cnt));
      run_instr(6'b000010, 1'b0, 0, 0);
      check("wrap count", 32'(instr_count), 32'd0);

      // Asynchronous reset in the middle of a stalled store.
      opcode = 6'b101011;
      mem_ready = 1'b1;
      repeat (3) tick();
      mem_ready = 1'b0;
      #1;
      check("sw in MEM_WRITE", 32'(state), 32'd6);
      check("mem_write before rst", 32'(mem_write), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("mem_write after rst", 32'(mem_write), 32'd0);
      check("state after rst", 32'(state), 32'd0);
      check("count after rst", 32'(instr_count), 32'd0);
      exp_cnt = 0;
      @(negedge clk);
      rst_n = 1'b1;
      mem_ready = 1'b1;
      #1;
      check("state after rerelease", 32'(state), 32'd0);
      tick();
      run_instr(6'b000000, 1'b0, 0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
